// File: rtl/fft_pkg.sv
// Shared widths, payload types and drain states for the FFT stage-0 datapath.
package fft_pkg;
   localparam int unsigned N_LANE = 16;
   localparam int unsigned N_PT   = 512;
   localparam int unsigned BEATS  = 32;
   localparam int unsigned IN_W   = 10;
   localparam int unsigned OUT_W  = 11;
   localparam int unsigned BEAT_W = 5;
   localparam int unsigned SLOTS  = 8;
   localparam int unsigned SLOT_W = 3;

   typedef struct packed {
      logic signed [IN_W-1:0] re;
      logic signed [IN_W-1:0] im;
   } cplx_in_t;

   typedef struct packed {
      logic signed [OUT_W-1:0] re;
      logic signed [OUT_W-1:0] im;
   } cplx_out_t;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_DRAIN = 1'b1
   } drain_st_e;
endpackage

// File: rtl/bfly2_lane.sv
// One lane of the BF-II butterfly: optional -j rotation of b, then a+b and a-b.
module bfly2_lane
   import fft_pkg::*;
(
   input  cplx_in_t  a,
   input  cplx_in_t  b,
   input  logic      rot,
   output cplx_out_t sum_c,
   output cplx_out_t diff_c
);
   logic signed [OUT_W-1:0] a_re, a_im, b_re, b_im, br, bi;

   // Extend before negating so -(-512) stays exact.
   assign a_re = OUT_W'($signed(a.re));
   assign a_im = OUT_W'($signed(a.im));
   assign b_re = OUT_W'($signed(b.re));
   assign b_im = OUT_W'($signed(b.im));

   assign br = rot ? b_im : b_re;
   assign bi = rot ? -b_re : b_im;

   assign sum_c.re  = a_re + br;
   assign sum_c.im  = a_im + bi;
   assign diff_c.re = a_re - br;
   assign diff_c.im = a_im - bi;
endmodule

// File: rtl/step0_1.sv
// Stage-0 BF-II: sums stream out with the second half of each group, differences drain afterwards.
module step0_1
   import fft_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             din_valid,
   input  logic [N_LANE-1:0][IN_W-1:0]      din_re,
   input  logic [N_LANE-1:0][IN_W-1:0]      din_im,
   output logic                             dout_valid,
   output logic [N_LANE-1:0][OUT_W-1:0]     dout_re,
   output logic [N_LANE-1:0][OUT_W-1:0]     dout_im,
   output logic [BEAT_W-1:0]                dout_beat
);
   logic [BEAT_W-1:0]              ib_q, ib_d;
   drain_st_e                      st_q, st_d;
   logic [SLOT_W-1:0]              dcnt_q, dcnt_d;
   logic                           dgrp_q, dgrp_d;
   logic                           dout_valid_q, dout_valid_d;
   logic [N_LANE-1:0][OUT_W-1:0]   dout_re_q, dout_re_d, dout_im_q, dout_im_d;
   logic [BEAT_W-1:0]              dout_beat_q, dout_beat_d;

   cplx_in_t  a_buf_q [SLOTS][N_LANE];
   cplx_out_t d_buf_q [SLOTS][N_LANE];

   cplx_in_t  din_c  [N_LANE];
   cplx_out_t sum_c  [N_LANE];
   cplx_out_t diff_c [N_LANE];

   logic              grp_c, half_c, rot_c;
   logic [SLOT_W-1:0] slot_c;

   assign grp_c  = ib_q[4];
   assign half_c = ib_q[3];
   assign slot_c = ib_q[2:0];
   assign rot_c  = ib_q[4] & ib_q[3];

   for (genvar i = 0; i < N_LANE; i++) begin : g_lane
      assign din_c[i].re = din_re[i];
      assign din_c[i].im = din_im[i];
      bfly2_lane u_lane (
         .a      (a_buf_q[slot_c][i]),
         .b      (din_c[i]),
         .rot    (rot_c),
         .sum_c  (sum_c[i]),
         .diff_c (diff_c[i])
      );
   end

   // Next-state: beat counter, drain sequencer, output register.
   always_comb begin
      ib_d         = ib_q;
      st_d         = st_q;
      dcnt_d       = dcnt_q;
      dgrp_d       = dgrp_q;
      dout_valid_d = 1'b0;
      dout_re_d    = dout_re_q;
      dout_im_d    = dout_im_q;
      dout_beat_d  = dout_beat_q;

      if (din_valid) begin
         ib_d = ib_q + BEAT_W'(1);
      end

      if (din_valid && half_c) begin
         dout_valid_d = 1'b1;
         dout_beat_d  = {grp_c, 1'b0, slot_c};
         for (int i = 0; i < N_LANE; i++) begin
            dout_re_d[i] = sum_c[i].re;
            dout_im_d[i] = sum_c[i].im;
         end
      end

      // A new group's first sum is at least 8 beats away, so draining never contends.
      case (st_q)
         S_IDLE: begin
            if (din_valid && (ib_q[3:0] == 4'hF)) begin
               st_d   = S_DRAIN;
               dcnt_d = '0;
               dgrp_d = grp_c;
            end
         end
         S_DRAIN: begin
            dout_valid_d = 1'b1;
            dout_beat_d  = {dgrp_q, 1'b1, dcnt_q};
            for (int i = 0; i < N_LANE; i++) begin
               dout_re_d[i] = d_buf_q[dcnt_q][i].re;
               dout_im_d[i] = d_buf_q[dcnt_q][i].im;
            end
            dcnt_d = dcnt_q + SLOT_W'(1);
            if (dcnt_q == SLOT_W'(SLOTS - 1)) begin
               st_d = S_IDLE;
            end
         end
         default: st_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ib_q         <= '0;
         st_q         <= S_IDLE;
         dcnt_q       <= '0;
         dgrp_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         dout_re_q    <= '0;
         dout_im_q    <= '0;
         dout_beat_q  <= '0;
      end else begin
         ib_q         <= ib_d;
         st_q         <= st_d;
         dcnt_q       <= dcnt_d;
         dgrp_q       <= dgrp_d;
         dout_valid_q <= dout_valid_d;
         dout_re_q    <= dout_re_d;
         dout_im_q    <= dout_im_d;
         dout_beat_q  <= dout_beat_d;
      end
   end

   // Sample buffers hold data only; they are never cleared.
   always_ff @(posedge clk) begin
      if (din_valid) begin
         for (int i = 0; i < N_LANE; i++) begin
            if (half_c) begin
               d_buf_q[slot_c][i] <= diff_c[i];
            end else begin
               a_buf_q[slot_c][i] <= din_c[i];
            end
         end
      end
   end

   assign dout_valid = dout_valid_q;
   assign dout_re    = dout_re_q;
   assign dout_im    = dout_im_q;
   assign dout_beat  = dout_beat_q;
endmodule

// File: tb/tb_step0_1.sv
// Scoreboard bench for step0_1: a reference butterfly model queues expected beats in output order.
`timescale 1ns/1ps
module tb_step0_1;
   import fft_pkg::*;

   localparam int unsigned VW = N_LANE * OUT_W;

   logic                          clk = 1'b0;
   logic                          rst = 1'b0;
   logic                          din_valid = 1'b0;
   logic [N_LANE-1:0][IN_W-1:0]   din_re = '0;
   logic [N_LANE-1:0][IN_W-1:0]   din_im = '0;
   logic                          dout_valid;
   logic [N_LANE-1:0][OUT_W-1:0]  dout_re, dout_im;
   logic [BEAT_W-1:0]             dout_beat;

   typedef struct {
      logic [BEAT_W-1:0]            beat;
      logic [N_LANE-1:0][OUT_W-1:0] re;
      logic [N_LANE-1:0][OUT_W-1:0] im;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   fr_re[N_PT];
   int   fr_im[N_PT];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   prev_valid = 1'b0;

   step0_1 dut (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (din_valid),
      .din_re     (din_re),
      .din_im     (din_im),
      .dout_valid (dout_valid),
      .dout_re    (dout_re),
      .dout_im    (dout_im),
      .dout_beat  (dout_beat)
   );

   always #1 clk = ~clk;

   task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference: rotate points 384..511, pair point p with p+128 inside each 256-point group.
   task automatic push_frame();
      int   xr[N_PT];
      int   xi[N_PT];
      int   pa, pb, r, q;
      exp_t e;
      for (int p = 0; p < N_PT; p++) begin
         if (p >= 384) begin
            xr[p] = fr_im[p];
            xi[p] = -fr_re[p];
         end else begin
            xr[p] = fr_re[p];
            xi[p] = fr_im[p];
         end
      end
      for (int g = 0; g < 2; g++) begin
         for (int half = 0; half < 2; half++) begin
            for (int k = 0; k < 8; k++) begin
               e.beat = BEAT_W'(g * 16 + half * 8 + k);
               for (int i = 0; i < N_LANE; i++) begin
                  pa = g * 256 + k * 16 + i;
                  pb = pa + 128;
                  r  = (half == 0) ? xr[pa] + xr[pb] : xr[pa] - xr[pb];
                  q  = (half == 0) ? xi[pa] + xi[pb] : xi[pa] - xi[pb];
                  e.re[i] = OUT_W'(r);
                  e.im[i] = OUT_W'(q);
               end
               sb.push_back(e);
            end
         end
      end
   endtask

   task automatic clear_frame();
      for (int p = 0; p < N_PT; p++) begin
         fr_re[p] = 0;
         fr_im[p] = 0;
      end
   endtask

   task automatic random_frame();
      for (int p = 0; p < N_PT; p++) begin
         fr_re[p] = $urandom_range(0, 1023) - 512;
         fr_im[p] = $urandom_range(0, 1023) - 512;
      end
   endtask

   task automatic random_din();
      for (int i = 0; i < N_LANE; i++) begin
         din_re[i] = IN_W'($urandom);
         din_im[i] = IN_W'($urandom);
      end
   endtask

   task automatic drive_beat(input int b, input int stall_max);
      int n;
      n = $urandom_range(0, stall_max);
      if (stall_max > 0 && b == 16) n = n + 2;
      repeat (n) begin
         din_valid = 1'b0;
         random_din();
         @(negedge clk);
      end
      for (int i = 0; i < N_LANE; i++) begin
         din_re[i] = IN_W'(fr_re[b * N_LANE + i]);
         din_im[i] = IN_W'(fr_im[b * N_LANE + i]);
      end
      din_valid = 1'b1;
      @(negedge clk);
   endtask

   task automatic drive_frame(input int stall_max);
      push_frame();
      for (int b = 0; b < BEATS; b++) drive_beat(b, stall_max);
      din_valid = 1'b0;
   endtask

   // Output monitor: pop expected beat per valid output, enforce contiguous drain.
   always @(negedge clk) begin
      if (!rst) begin
         prev_valid = 1'b0;
      end else begin
         if (dout_valid) begin
            if (sb.size() == 0) begin
               check("unexpected_valid", VW'(dout_valid), VW'(0));
            end else begin
               mon_e = sb.pop_front();
               check("dout_beat", VW'(dout_beat), VW'(mon_e.beat));
               check("dout_re", dout_re, mon_e.re);
               check("dout_im", dout_im, mon_e.im);
               if (mon_e.beat[3] && (mon_e.beat[2:0] != 3'd0)) begin
                  check("drain_gap", VW'(prev_valid), VW'(1));
               end
            end
         end
         prev_valid = dout_valid;
      end
   end

   initial begin
      int budget;
      // Reset with random input activity.
      rst = 1'b0;
      repeat (6) begin
         din_valid = 1'($urandom);
         random_din();
         @(negedge clk);
         check("rst_valid", VW'(dout_valid), VW'(0));
         check("rst_re", dout_re, '0);
         check("rst_im", dout_im, '0);
         check("rst_beat", VW'(dout_beat), VW'(0));
      end
      din_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);

      // Impulse at point 0.
      clear_frame();
      fr_re[0] = 100;
      drive_frame(0);

      // Rotated extreme at point 384.
      clear_frame();
      fr_re[384] = -512;
      fr_im[384] = 7;
      drive_frame(0);

      // Full-scale group 1.
      clear_frame();
      for (int p = 256; p < 384; p++) begin fr_re[p] = 511;  fr_im[p] = -512; end
      for (int p = 384; p < 512; p++) begin fr_re[p] = -512; fr_im[p] = 511;  end
      drive_frame(0);

      // Random data with input stalls.
      random_frame();
      drive_frame(3);
      random_frame();
      drive_frame(2);

      // Three back-to-back frames.
      for (int f = 0; f < 3; f++) begin
         random_frame();
         drive_frame(0);
      end

      // Mid-frame reset at beat 20.
      random_frame();
      push_frame();
      for (int b = 0; b < 20; b++) drive_beat(b, 0);
      din_valid = 1'b0;
      @(posedge clk);
      #0.5;
      rst = 1'b0;
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      random_frame();
      drive_frame(0);

      budget = 200;
      while (sb.size() != 0 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("sb_drained", VW'(sb.size()), VW'(0));
      repeat (4) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
